zet_int_sched: RTL
==================

Name: zet_int_sched

Overview:
- Interrupt scheduler for the Zet core: collects 8 edge-triggered IRQ lines plus NMI and resolves priority.
- Drives the decoder's intr/nmir request inputs and consumes its inta/nmia acknowledge pulses.
- Supplies the 8-bit vector that the interrupt microcode reads.
- Sits between the PC peripherals (timer, keyboard, etc.) and zet_decode; programmed by CPU I/O writes.

Parameters:
- RST_BASE, 5'h01: reset vector base; vector = {base, irq index}, so the reset base maps IRQ0 to 8'h08.
- RST_MASK, 8'hFF: reset interrupt mask; all IRQs masked.

Ports:
- clk in 1: clock
- rst in 1: reset, synchronous, active-high
- irq in 8: peripheral request lines, rising-edge sensitive, bit 0 highest priority
- nmi_in in 1: non-maskable request, rising-edge sensitive
- inta in 1: one-cycle acknowledge pulse from decoder
- nmia in 1: one-cycle NMI acknowledge pulse from decoder
- eoi in 1: one-cycle non-specific end-of-interrupt strobe
- mask_we in 1: write strobe for mask
- mask_wd in 8: new mask value
- base_we in 1: write strobe for vector base
- base_wd in 5: new vector base
- intr out 1: maskable request to decoder
- nmir out 1: NMI request to decoder
- vector out 8: acknowledged vector, registered
- irr out 8: request register
- isr out 8: in-service register
- imr out 8: mask register

Behaviour:
- Reset: intr=0, nmir=0, vector=0, irr=0, isr=0, imr=RST_MASK, base=RST_BASE, irq_d=0, nmi_d=0, state=IDLE. Reset mid-operation discards all pending and in-service state.
- Edge detect: irq_d/nmi_d are registered copies of the inputs. A bit is set in irr when irq & ~irq_d; nmir is set when nmi_in & ~nmi_d.
- Candidate: lowest index n with irr[n] & ~imr[n]. It is eligible only if isr has no bit at index ≤ n.
- State machine, 2 states:
  - IDLE: on an eligible candidate, latch sel=n, intr<=1, go PEND. Takes 1 cycle from the irr bit being set to intr high.
  - PEND: intr held at 1. sel stays frozen, even if the mask, irr or base change meanwhile.
  - PEND on inta: vector<={base,sel}, irr[sel]<=0, isr[sel]<=1, intr<=0 next cycle, return to IDLE.
  - PEND with sel newly masked via mask_we: intr<=0, return to IDLE; irr[sel] is retained.
- Spurious inta while IDLE: vector<={base,3'd7}; irr and isr unchanged.
- EOI: clears the lowest-index set bit of isr. EOI with isr=0 has no effect.
- Simultaneous events:
  - New edge on irq[sel] in the same cycle as inta: irr[sel] stays 1 (new request wins).
  - eoi and inta in the same cycle: EOI clear is applied first, then the ack set.
  - New candidate arbitration uses the updated isr/irr in the following cycle.
  - mask_we and inta in the same cycle: the ack completes using the frozen sel.
- NMI: nmir is cleared by nmia. A new nmi_in edge in the same cycle as nmia keeps nmir=1. NMI is independent of imr, isr and the state machine.
- Writes: mask_we and base_we take effect the next cycle. imr/irr/isr outputs are the direct register values.

Optional Feature:
- Macro ZET_INT_SCHED_AUTO_EOI_EN.
- Defined: inta does not set isr (isr is constant 0), the eoi input is ignored, and eligibility depends only on irr & ~imr.
- Not defined: normal in-service tracking and eoi handling as described above.

Decomposition:
- Package zet_int_sched_pkg holds: state encoding (IDLE, PEND), SPURIOUS_IDX=3'd7, the vector-width constant and the IRQ count (8).
- One sub-module, zet_int_prio: 8-bit lowest-index-first priority encoder with outputs idx[2:0] and valid. Instantiated twice, once for the candidate and once for the highest in-service bit, both used for eligibility and for EOI.

Test Plan:
- Reset, then imr<=8'h00, pulse irq[1] → intr=1 two cycles after the edge. inta → vector=8'h09, isr=8'h02, irr=0, intr=0.
- irq[3] in service, then edge on irq[5] → intr stays 0. eoi → isr=0, then intr=1. inta → vector=8'h0D.
- While isr[5] is set, edge on irq[0] → nesting: intr=1, inta gives vector 8'h08, isr=8'h21. eoi clears bit 0 only → isr=8'h20.
- In PEND with sel=2, mask_we with mask_wd=8'h04 → intr drops, irr[2] stays 1. Unmask → intr reasserts.
- inta while IDLE → vector=8'h0F, isr unchanged. Then base_we with base_wd=5'h0E and irq[0] ack → vector=8'h70.
- nmi_in edge → nmir=1. Second edge coincident with nmia → nmir stays 1; a further nmia → nmir=0. With ZET_INT_SCHED_AUTO_EOI_EN defined: ack of irq[4] leaves isr=0 and an immediate irq[6] edge raises intr.

Source files
------------

// File: rtl/zet_int_sched_pkg.sv
// Shared constants and types for the Zet interrupt scheduler.
package zet_int_sched_pkg;

  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = 8;

  localparam logic [2:0] SPURIOUS_IDX = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // One-hot mask for an IRQ index, used to set/clear single irr/isr bits.
  function automatic logic [NUM_IRQ-1:0] idx_onehot(input logic [2:0] idx);
    idx_onehot = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/zet_int_prio.sv
// Lowest-index-first priority encoder over 8 request bits.
module zet_int_prio
  import zet_int_sched_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Bit 0 has the highest priority.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b1;
    casez (req)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default: begin
        idx   = 3'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/zet_int_sched.sv
// Interrupt scheduler: 8 edge-triggered IRQs plus NMI feeding zet_decode.
// Optional build macro: ZET_INT_SCHED_AUTO_EOI_EN (no in-service tracking, eoi ignored).
module zet_int_sched
  import zet_int_sched_pkg::*;
#(
  parameter logic [4:0] RST_BASE = 5'h01,
  parameter logic [7:0] RST_MASK = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_in,
  input  logic               inta,
  input  logic               nmia,
  input  logic               eoi,
  input  logic               mask_we,
  input  logic [7:0]         mask_wd,
  input  logic               base_we,
  input  logic [4:0]         base_wd,
  output logic               intr,
  output logic               nmir,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr
);

  state_t             state;
  state_t             state_next;
  logic [2:0]         sel;
  logic [2:0]         sel_next;
  logic [4:0]         base;
  logic [4:0]         base_next;
  logic [NUM_IRQ-1:0] irq_d;
  logic               nmi_d;

  logic               intr_next;
  logic               nmir_next;
  logic [VEC_W-1:0]   vector_next;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] isr_next;
  logic [NUM_IRQ-1:0] imr_next;

  logic [NUM_IRQ-1:0] irq_edge;
  logic               nmi_edge;
  logic               ack;
  logic [NUM_IRQ-1:0] ack_bits;

  logic [2:0]         cand_idx;
  logic               cand_valid;
  logic [2:0]         isr_idx;
  logic               isr_valid;
  logic               eligible;

  assign irq_edge = irq & ~irq_d;
  assign nmi_edge = nmi_in & ~nmi_d;

  zet_int_prio u_cand (
    .req   (irr & ~imr),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  zet_int_prio u_insvc (
    .req   (isr),
    .idx   (isr_idx),
    .valid (isr_valid)
  );

`ifdef ZET_INT_SCHED_AUTO_EOI_EN
  assign eligible = cand_valid;
`else
  // A candidate may only nest above strictly lower-priority in-service bits.
  assign eligible = cand_valid & (~isr_valid | (isr_idx > cand_idx));
`endif

  // Next-state and next-output logic for the request/acknowledge FSM.
  always_comb begin
    state_next  = state;
    sel_next    = sel;
    intr_next   = intr;
    vector_next = vector;
    ack         = 1'b0;
    case (state)
      IDLE: begin
        if (inta) begin
          vector_next = {base, SPURIOUS_IDX};
        end else begin
          vector_next = vector;
        end
        if (eligible) begin
          sel_next   = cand_idx;
          intr_next  = 1'b1;
          state_next = PEND;
        end else begin
          intr_next  = 1'b0;
        end
      end
      PEND: begin
        // Ack beats a same-cycle mask write; sel stays frozen throughout.
        if (inta) begin
          ack         = 1'b1;
          vector_next = {base, sel};
          intr_next   = 1'b0;
          state_next  = IDLE;
        end else if (mask_we && mask_wd[sel]) begin
          intr_next   = 1'b0;
          state_next  = IDLE;
        end else begin
          intr_next   = 1'b1;
        end
      end
      default: begin
        intr_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Request, in-service, mask, base and NMI next values.
  always_comb begin
    ack_bits  = ack ? idx_onehot(sel) : 8'h00;
    irr_next  = (irr & ~ack_bits) | irq_edge;
`ifdef ZET_INT_SCHED_AUTO_EOI_EN
    isr_next  = 8'h00;
`else
    isr_next  = isr;
    if (eoi && isr_valid) begin
      isr_next = isr_next & ~idx_onehot(isr_idx);
    end else begin
      isr_next = isr;
    end
    isr_next  = isr_next | ack_bits;
`endif
    imr_next  = mask_we ? mask_wd : imr;
    base_next = base_we ? base_wd : base;
    nmir_next = nmi_edge | (nmir & ~nmia);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr   <= 1'b0;
      nmir   <= 1'b0;
      vector <= 8'h00;
      irr    <= 8'h00;
      isr    <= 8'h00;
      imr    <= RST_MASK;
      base   <= RST_BASE;
      irq_d  <= 8'h00;
      nmi_d  <= 1'b0;
    end else begin
      intr   <= intr_next;
      nmir   <= nmir_next;
      vector <= vector_next;
      irr    <= irr_next;
      isr    <= isr_next;
      imr    <= imr_next;
      base   <= base_next;
      irq_d  <= irq;
      nmi_d  <= nmi_in;
    end
  end

endmodule
